ssd_scan_controller: RTL and testbench
======================================

# ssd_scan_controller

Time-multiplexed scan controller for the clock's multi-digit seven-segment display. It holds the BCD digits to be shown and sequences one shared BCD-to-seven-segment decoder across all digit positions. It drives the decoder's `bcd` input and registers the decoder's `ssd` result onto the shared segment bus, while stepping the active-low anode selects. It sits between the timekeeping counters (digit source) and the board display pins.

## Interface
- `NUM_DIGITS`, 6: number of digit positions; digit 0 is the rightmost (least significant).
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ `GUARD_CYCLES`+2.
- `GUARD_CYCLES`, 2: cycles at the start of each slot with all anodes off (anti-ghosting).

- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `digits_in` in 4*NUM_DIGITS: BCD digits; nibble i (bits 4i+3:4i) is digit i.
- `load` in 1: single-cycle request to capture `digits_in`.
- `load_ack` out 1: one-cycle pulse when captured digits become visible.
- `blink_mask` in NUM_DIGITS: digits that blink.
- `blink_tick` in 1: single-cycle pulse; toggles blink phase.
- `bcd` out 4: digit code to shared decoder.
- `ssd_in` in 7: decoder result, active-low segments, combinational from `bcd`.
- `seg` out 7: registered segment bus, active-low (1 = off).
- `an` out NUM_DIGITS: registered anode selects, active-low, at most one low.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- Registers: `staging` and `display` (4*NUM_DIGITS each), `pending` flag, `idx` (digit index), `cnt` (slot cycle counter), `phase` (blink), `state`.
- FSM, two states:
  - GUARD: `an` all 1, `seg` all 1, `bcd` = `display[idx]`. Lasts for `cnt` 0..GUARD_CYCLES-1.
  - DRIVE: `an[idx]` = 0, `seg` = decoded or blank. Lasts for `cnt` GUARD_CYCLES..REFRESH_DIV-1.
- At `cnt` = REFRESH_DIV-1: `cnt` ← 0, state ← GUARD, and `idx` increments, wrapping NUM_DIGITS-1 → 0.
- `seg` is loaded on the GUARD→DRIVE edge and held constant through DRIVE.
- The digit is blanked (`seg` = 7'b1111111) when any of the following holds:
  - its nibble > 9 (the decoder output is undefined for such codes, so `ssd_in` is ignored);
  - `blink_mask[idx]` = 1 and `phase` = 1;
  - leading-zero blanking applies (see Configuration).
- `load`: `staging` ← `digits_in` and `pending` ← 1. A repeated `load` before transfer overwrites `staging`; only one ack results.
- Frame boundary is the edge where `idx` wraps to 0. On that edge:
  - if `pending`: `display` ← `staging`, `pending` ← 0, `load_ack` ← 1;
  - `frame_done` ← 1.
  - Both pulses last exactly one cycle.
- `load` on the boundary cycle: `digits_in` goes directly into `display` with `load_ack` on that edge, and `pending` stays 0. Digits therefore never change mid-frame (no tearing).
- `blink_tick`: `phase` ← ~`phase`. The effect appears at the next GUARD→DRIVE edge.

## Timing
- Reset values:
  - `seg` = 7'b1111111, `an` all 1, `bcd` = 0, `load_ack` = 0, `frame_done` = 0;
  - `display` = `staging` = 0, `pending` = 0, `idx` = 0, `cnt` = 0, `phase` = 0, state GUARD.
- `rst` mid-frame overrides all other activity and discards any pending load.
- First anode low is at cycle GUARD_CYCLES after reset release: `an[0]` = 0.
- `bcd` is valid from the first GUARD cycle, giving the decoder ≥ GUARD_CYCLES cycles to settle.
- Slot = REFRESH_DIV cycles; frame = NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-visible latency: up to 1 frame + GUARD_CYCLES.

## Configuration
- `SSD_LEADING_ZERO_BLANK_EN` defined: digits from NUM_DIGITS-1 downward are blanked while they and all more-significant digits are 0. Digit 0 is never blanked by this rule.
- Not defined: zeros are always displayed; no leading-zero logic is synthesized.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset release with `display` = 0 -> `an` = 4'b1111 for 2 cycles, then 4'b1110 for 6 cycles; `seg` = 7'b0000001; `frame_done` pulses every 32 cycles.
- `load` with `digits_in` = 16'h1234 mid-frame -> old digits persist to frame end; `load_ack` and `frame_done` pulse together; next frame shows 4, 3, 2, 1 on `an[0..3]`, with digit 1 as `seg` = 7'b1001111.
- Two `load`s (16'h1111, then 16'h2222) in one frame -> single `load_ack`; 16'h2222 displayed.
- Nibble 4'hA in digit 2 -> `seg` = 7'b1111111 during digit 2's slot; other digits unaffected.
- `blink_mask` = 4'b0001 with a `blink_tick` pulse -> digit 0 blanked, others lit; a second tick restores digit 0.
- With `SSD_LEADING_ZERO_BLANK_EN`, `display` = 16'h0050 -> digits 3 and 2 blank; digit 1 shows 5 (7'b0100100); digit 0 shows 0. Without the macro, all four digits are lit.

Source files
------------

// File: rtl/ssd_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_controller_if
// Brief    : Digit-source, decoder and display-pin signals of the scan controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ssd_scan_controller_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic                    load_ack;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_tick;
  logic [3:0]              bcd;
  logic [6:0]              ssd_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  // master: digit source + decoder side; slave: the scan controller itself
  modport master (
    output digits_in, load, blink_mask, blink_tick, ssd_in,
    input  load_ack, bcd, seg, an, frame_done
  );

  modport slave (
    input  digits_in, load, blink_mask, blink_tick, ssd_in,
    output load_ack, bcd, seg, an, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_controller
// Brief    : Time-multiplexed seven-segment scan with tear-free digit loads.
//            Optional macro SSD_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_controller #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  ssd_scan_controller_if.slave scan_if
);

  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_DW    = 4 * NUM_DIGITS;

  localparam logic [c_IDX_W-1:0]    c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_LAST   = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_CNT_W-1:0]    c_GUARD_LAST = c_CNT_W'(GUARD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0]    c_IDX_ONE    = c_IDX_W'(1);
  localparam logic [NUM_DIGITS-1:0] c_AN_ONE     = NUM_DIGITS'(1);
  localparam logic [6:0]            c_SEG_OFF    = 7'h7F;

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [c_DW-1:0]       staging_q, staging_d;
  logic [c_DW-1:0]       display_q, display_d;
  logic                  pending_q, pending_d;
  logic [c_IDX_W-1:0]    idx_q, idx_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            w_digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic [3:0]            w_cur_digit;
  logic                  w_blank;
  logic                  w_guard_end;
  logic                  w_slot_end;
  logic                  w_frame_end;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign w_digits[i] = display_q[4*i +: 4];
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are 0
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lzb
    if (i == 0) begin : g_units
      assign w_lz_blank[i] = 1'b0;
    end else begin : g_upper
      assign w_lz_blank[i] = ~|display_q[c_DW-1:4*i];
    end
  end
`else
  assign w_lz_blank = '0;
`endif

  assign w_cur_digit = w_digits[idx_q];
  assign w_blank     = (w_cur_digit > 4'd9)
                     | (scan_if.blink_mask[idx_q] & phase_q)
                     | w_lz_blank[idx_q];

  assign w_guard_end = (state_q == ST_GUARD) && (cnt_q == c_GUARD_LAST);
  assign w_slot_end  = (state_q == ST_DRIVE) && (cnt_q == c_CNT_LAST);
  assign w_frame_end = w_slot_end && (idx_q == c_IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GUARD;
      staging_q    <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      seg_q        <= c_SEG_OFF;
      an_q         <= '1;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      staging_q    <= staging_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    staging_d    = staging_q;
    display_d    = display_q;
    pending_d    = pending_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + c_CNT_ONE;
    phase_d      = phase_q ^ scan_if.blink_tick;
    seg_d        = seg_q;
    an_d         = an_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_GUARD: begin
        if (w_guard_end) begin
          state_d = ST_DRIVE;
          an_d    = ~(c_AN_ONE << idx_q);
          seg_d   = w_blank ? c_SEG_OFF : scan_if.ssd_in;
        end
      end
      ST_DRIVE: begin
        if (w_slot_end) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          an_d    = '1;
          seg_d   = c_SEG_OFF;
          idx_d   = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IDX_ONE;
        end
      end
      default: begin
        state_d = ST_GUARD;
        cnt_d   = '0;
        an_d    = '1;
        seg_d   = c_SEG_OFF;
      end
    endcase

    // Digits only change at the frame boundary; a load on that very edge bypasses staging
    if (w_frame_end) begin
      frame_done_d = 1'b1;
      if (scan_if.load) begin
        display_d  = scan_if.digits_in;
        staging_d  = scan_if.digits_in;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (pending_q) begin
        display_d  = staging_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end
    end else if (scan_if.load) begin
      staging_d = scan_if.digits_in;
      pending_d = 1'b1;
    end
  end

  assign scan_if.bcd        = w_cur_digit;
  assign scan_if.seg        = seg_q;
  assign scan_if.an         = an_q;
  assign scan_if.load_ack   = load_ack_q;
  assign scan_if.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_controller
// Brief    : Directed self-checking bench for ssd_scan_controller (4 digits, slot 8, guard 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

  localparam int c_ND = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  ssd_scan_controller_if #(.NUM_DIGITS(c_ND)) bus ();

  ssd_scan_controller #(
    .NUM_DIGITS  (c_ND),
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scan_if(bus)
  );

  // Reference decoder, segments abcdefg active-low; non-BCD codes give a lit pattern
  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = 7'b0001000;
    endcase
  endfunction

  always_comb bus.ssd_in = dec(bus.bcd);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d);
    bus.digits_in = d;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
  endtask

  task automatic pulse_blink();
    bus.blink_tick = 1'b1;
    tick();
    bus.blink_tick = 1'b0;
  endtask

  logic [6:0] lz_exp;

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.digits_in  = '0;
    bus.blink_mask = '0;
    bus.blink_tick = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    lz_exp = 7'b1111111;
`else
    lz_exp = 7'b0000001;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", bus.an, 4'b1111);
    chk("rst_seg", bus.seg, 7'b1111111);
    chk("rst_bcd", bus.bcd, 4'd0);
    chk("rst_ack", bus.load_ack, 1'b0);
    chk("rst_fd", bus.frame_done, 1'b0);

    rst = 1'b0;
    cyc = 0;
    chk("guard0_an", bus.an, 4'b1111);
    wait_to(1);  chk("guard1_an", bus.an, 4'b1111);
    wait_to(2);  chk("drive0_an", bus.an, 4'b1110);
                 chk("drive0_seg", bus.seg, 7'b0000001);
    wait_to(7);  chk("drive0_end_an", bus.an, 4'b1110);
    wait_to(8);  chk("slot1_guard_an", bus.an, 4'b1111);
                 chk("slot1_guard_seg", bus.seg, 7'b1111111);
    wait_to(10); chk("slot1_drive_an", bus.an, 4'b1101);
    wait_to(31); chk("fd_before", bus.frame_done, 1'b0);
    wait_to(32); chk("fd_frame1", bus.frame_done, 1'b1);
    wait_to(33); chk("fd_after", bus.frame_done, 1'b0);

    // load mid-frame: old digits persist until the boundary at cycle 64
    wait_to(40); pulse_load(16'h1234);
    wait_to(42); chk("old_digit1_an", bus.an, 4'b1101);
                 chk("old_digit1_seg", bus.seg, 7'b0000001);
    wait_to(63); chk("ack_not_early", bus.load_ack, 1'b0);
    wait_to(64); chk("ack_1234", bus.load_ack, 1'b1);
                 chk("fd_with_ack", bus.frame_done, 1'b1);
    wait_to(65); chk("ack_one_cycle", bus.load_ack, 1'b0);
    wait_to(66); chk("d0_an", bus.an, 4'b1110);
                 chk("d0_is_4", bus.seg, 7'b1001100);
    wait_to(74); chk("d1_an", bus.an, 4'b1101);
                 chk("d1_is_3", bus.seg, 7'b0000110);
    wait_to(82); chk("d2_an", bus.an, 4'b1011);
                 chk("d2_is_2", bus.seg, 7'b0010010);
    wait_to(90); chk("d3_an", bus.an, 4'b0111);
                 chk("d3_is_1", bus.seg, 7'b1001111);
    wait_to(96); chk("no_ack_idle", bus.load_ack, 1'b0);
                 chk("fd_frame3", bus.frame_done, 1'b1);

    // two loads in one frame: last one wins, single ack
    wait_to(100); pulse_load(16'h1111);
    wait_to(110); pulse_load(16'h2222);
    wait_to(128); chk("ack_double_load", bus.load_ack, 1'b1);
    wait_to(130); chk("d0_is_2", bus.seg, 7'b0010010);
    wait_to(160); chk("no_second_ack", bus.load_ack, 1'b0);
                  chk("fd_frame5", bus.frame_done, 1'b1);

    // non-BCD nibble in digit 2 is blanked regardless of decoder output
    wait_to(170); pulse_load(16'h3A21);
    wait_to(192); chk("ack_3a21", bus.load_ack, 1'b1);
    wait_to(194); chk("bad_d0_is_1", bus.seg, 7'b1001111);
    wait_to(202); chk("bad_d1_is_2", bus.seg, 7'b0010010);
    wait_to(208); chk("bcd_digit2", bus.bcd, 4'hA);
    wait_to(210); chk("bad_d2_an", bus.an, 4'b1011);
                  chk("bad_d2_blank", bus.seg, 7'b1111111);
    wait_to(218); chk("bad_d3_an", bus.an, 4'b0111);
                  chk("bad_d3_is_3", bus.seg, 7'b0000110);

    // blink: phase toggles, digit 0 masked
    wait_to(224); bus.blink_mask = 4'b0001; pulse_blink();
    wait_to(226); chk("blink_d0_an", bus.an, 4'b1110);
                  chk("blink_d0_blank", bus.seg, 7'b1111111);
    wait_to(234); chk("blink_d1_lit", bus.seg, 7'b0010010);
    wait_to(240); pulse_blink();
    wait_to(258); chk("unblink_d0_an", bus.an, 4'b1110);
                  chk("unblink_d0_lit", bus.seg, 7'b1001111);

    // leading zeros
    wait_to(260); pulse_load(16'h0050);
    wait_to(288); chk("ack_0050", bus.load_ack, 1'b1);
    wait_to(290); chk("lz_d0_zero", bus.seg, 7'b0000001);
    wait_to(298); chk("lz_d1_five", bus.seg, 7'b0100100);
    wait_to(306); chk("lz_d2", bus.seg, {25'd0, lz_exp});
    wait_to(314); chk("lz_d3", bus.seg, {25'd0, lz_exp});

    // reset mid-frame discards a pending load
    wait_to(315); pulse_load(16'h9999);
    wait_to(318);
    rst = 1'b1;
    tick();
    tick();
    chk("mid_rst_an", bus.an, 4'b1111);
    chk("mid_rst_seg", bus.seg, 7'b1111111);
    chk("mid_rst_fd", bus.frame_done, 1'b0);
    rst = 1'b0;
    cyc = 0;
    wait_to(10); chk("post_rst_d1_an", bus.an, 4'b1101);
                 chk("post_rst_d1_zero", bus.seg, 7'b0000001);
    wait_to(32); chk("post_rst_no_ack", bus.load_ack, 1'b0);
                 chk("post_rst_fd", bus.frame_done, 1'b1);
    wait_to(34); chk("post_rst_d0_an", bus.an, 4'b1110);
                 chk("post_rst_d0_zero", bus.seg, 7'b0000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
